// File: rtl/dmlb_resp.sv
// rtl/dmlb_resp.sv - fully-associative translation buffer with split-page lookup and single-miss refill FSM.
// Optional lookup statistics counters are built when DMLB_RESP_STATS_EN is defined.
module dmlb_resp #(
  parameter int ENTRIES    = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mlb_clkEn,
  input  logic [51:0]           addrTlb,
  input  logic                  mlb_need_next,
  output logic [DATA_WIDTH-1:0] mlb_data0,
  output logic [DATA_WIDTH-1:0] mlb_data1,
  output logic                  mlb_hit,
  output logic                  miss_req,
  output logic [51:0]           miss_addr,
  input  logic                  miss_ack,
  input  logic                  refill_en,
  input  logic [51:0]           refill_addr,
  input  logic [DATA_WIDTH-1:0] refill_data,
  input  logic                  inv_all,
  output logic                  miss_busy,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);

  localparam int PTR_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  logic [ENTRIES-1:0]    valid_q;
  logic [51:0]           tag_q  [ENTRIES];
  logic [DATA_WIDTH-1:0] data_q [ENTRIES];
  logic [PTR_W-1:0]      victim_q;

  state_e                state_q, state_d;
  logic [51:0]           miss_addr_q, miss_addr_d;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;

  logic [51:0]           next_tag;
  logic                  hit0, hit1, lookup_hit;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic                  ref_hit;
  logic [PTR_W-1:0]      ref_idx, wr_idx;
  logic                  wr_en;

  // Only the VA field increments; the process field is carried through untouched.
  assign next_tag = {addrTlb[51:31], addrTlb[30:0] + 31'd1};

  always_comb begin
    hit0    = 1'b0;
    hit1    = 1'b0;
    rd0     = '0;
    rd1     = '0;
    ref_hit = 1'b0;
    ref_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == addrTlb) begin
        hit0 = 1'b1;
        rd0  = data_q[i];
      end
      if (valid_q[i] && tag_q[i] == next_tag) begin
        hit1 = 1'b1;
        rd1  = data_q[i];
      end
      if (valid_q[i] && tag_q[i] == refill_addr) begin
        ref_hit = 1'b1;
        ref_idx = PTR_W'(i);
      end
    end
    lookup_hit = hit0 & (hit1 | ~mlb_need_next);
  end

  // A flush in the same cycle wins over the refill, which is simply lost.
  assign wr_en  = refill_en & ~inv_all;
  assign wr_idx = ref_hit ? ref_idx : victim_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= refill_addr;
      data_q[wr_idx] <= refill_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      if (!ref_hit) begin
        victim_q <= victim_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else if (mlb_clkEn) begin
      hit_q   <= lookup_hit;
      data0_q <= rd0;
      data1_q <= rd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    if (inv_all) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Only one outstanding miss; requests that miss elsewhere are replayed.
          if (mlb_clkEn && !lookup_hit) begin
            state_d     = REQ;
            miss_addr_d = hit0 ? next_tag : addrTlb;
          end
        end
        REQ: begin
          if (miss_ack) state_d = WAIT;
        end
        WAIT: begin
          if (refill_en && refill_addr == miss_addr_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mlb_hit   = hit_q;
  assign mlb_data0 = data0_q;
  assign mlb_data1 = data1_q;
  assign miss_req  = (state_q == REQ);
  assign miss_addr = miss_addr_q;
  assign miss_busy = (state_q != IDLE);

`ifdef DMLB_RESP_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (mlb_clkEn) begin
      if (lookup_hit) begin
        if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_dmlb_resp.sv
// tb/tb_dmlb_resp.sv - directed self-checking bench for dmlb_resp.
module tb_dmlb_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mlb_clkEn = 1'b0;
  logic [51:0] addrTlb = '0;
  logic        mlb_need_next = 1'b0;
  logic [63:0] mlb_data0, mlb_data1;
  logic        mlb_hit, miss_req, miss_busy;
  logic [51:0] miss_addr;
  logic        miss_ack = 1'b0;
  logic        refill_en = 1'b0;
  logic [51:0] refill_addr = '0;
  logic [63:0] refill_data = '0;
  logic        inv_all = 1'b0;
  logic [31:0] stat_hits, stat_misses;

  int tests_run    = 0;
  int tests_failed = 0;

  dmlb_resp #(.ENTRIES(16), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .mlb_clkEn(mlb_clkEn), .addrTlb(addrTlb),
    .mlb_need_next(mlb_need_next), .mlb_data0(mlb_data0), .mlb_data1(mlb_data1),
    .mlb_hit(mlb_hit), .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
    .refill_en(refill_en), .refill_addr(refill_addr), .refill_data(refill_data),
    .inv_all(inv_all), .miss_busy(miss_busy), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  // All helpers start and end on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lookup(input logic [51:0] tag, input logic need);
    mlb_clkEn = 1'b1;
    addrTlb = tag;
    mlb_need_next = need;
    @(negedge clk);
    mlb_clkEn = 1'b0;
  endtask

  task automatic ack();
    miss_ack = 1'b1;
    @(negedge clk);
    miss_ack = 1'b0;
  endtask

  task automatic refill(input logic [51:0] tag, input logic [63:0] data);
    refill_en = 1'b1;
    refill_addr = tag;
    refill_data = data;
    @(negedge clk);
    refill_en = 1'b0;
  endtask

  task automatic fill(input logic [51:0] tag, input logic [63:0] data);
    lookup(tag, 1'b0);
    ack();
    refill(tag, data);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit got %b exp 0", mlb_hit); end
    tests_run++; if (miss_req !== 1'b0) begin tests_failed++; $display("FAIL reset_miss_req got %b exp 0", miss_req); end
    tests_run++; if (miss_addr !== 52'h0) begin tests_failed++; $display("FAIL reset_miss_addr got %h exp 0", miss_addr); end
    tests_run++; if (mlb_data0 !== 64'h0 || mlb_data1 !== 64'h0) begin tests_failed++; $display("FAIL reset_data got %h/%h exp 0/0", mlb_data0, mlb_data1); end
    tests_run++; if (miss_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", miss_busy); end
    tests_run++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin tests_failed++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_hits, stat_misses); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_miss();
    lookup(52'h0000000001000, 1'b0);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL basic_first_hit got %b exp 0", mlb_hit); end
    tests_run++; if (miss_req !== 1'b1) begin tests_failed++; $display("FAIL basic_miss_req got %b exp 1", miss_req); end
    tests_run++; if (miss_addr !== 52'h0000000001000) begin tests_failed++; $display("FAIL basic_miss_addr got %h exp 1000", miss_addr); end
    ack();
    tests_run++; if (miss_req !== 1'b0 || miss_busy !== 1'b1) begin tests_failed++; $display("FAIL basic_wait got req=%b busy=%b exp 0/1", miss_req, miss_busy); end
    refill(52'h0000000001000, 64'hAB);
    tests_run++; if (miss_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle got busy=%b exp 0", miss_busy); end
    lookup(52'h0000000001000, 1'b0);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'hAB || mlb_data1 !== 64'h0) begin
      tests_failed++; $display("FAIL basic_hit got hit=%b d0=%h d1=%h exp 1/ab/0", mlb_hit, mlb_data0, mlb_data1); end
  endtask

  task automatic test_split();
    lookup(52'h0000000001000, 1'b1);
    tests_run++; if (mlb_hit !== 1'b0 || mlb_data0 !== 64'hAB || mlb_data1 !== 64'h0) begin
      tests_failed++; $display("FAIL split_miss got hit=%b d0=%h d1=%h exp 0/ab/0", mlb_hit, mlb_data0, mlb_data1); end
    tests_run++; if (miss_addr !== 52'h0000000001001 || miss_req !== 1'b1) begin
      tests_failed++; $display("FAIL split_miss_addr got %h req=%b exp 1001/1", miss_addr, miss_req); end
    ack();
    refill(52'h0000000001001, 64'hCD);
    lookup(52'h0000000001000, 1'b1);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'hAB || mlb_data1 !== 64'hCD) begin
      tests_failed++; $display("FAIL split_hit got hit=%b d0=%h d1=%h exp 1/ab/cd", mlb_hit, mlb_data0, mlb_data1); end
  endtask

  task automatic test_wrap();
    fill(52'h000007FFFFFFF, 64'h11);
    lookup(52'h000007FFFFFFF, 1'b1);
    tests_run++; if (mlb_hit !== 1'b0 || miss_addr !== 52'h0) begin
      tests_failed++; $display("FAIL wrap_next got hit=%b addr=%h exp 0/0", mlb_hit, miss_addr); end
    ack();
    refill(52'h0, 64'h22);
    lookup(52'h000007FFFFFFF, 1'b1);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'h11 || mlb_data1 !== 64'h22) begin
      tests_failed++; $display("FAIL wrap_hit got hit=%b d0=%h d1=%h exp 1/11/22", mlb_hit, mlb_data0, mlb_data1); end
    fill(52'h00001FFFFFFFF, 64'h33);
    lookup(52'h00001FFFFFFFF, 1'b1);
    tests_run++; if (mlb_hit !== 1'b0 || miss_addr !== 52'h0000180000000) begin
      tests_failed++; $display("FAIL wrap_proc got hit=%b addr=%h exp 0/180000000", mlb_hit, miss_addr); end
    ack();
    refill(52'h0000180000000, 64'h44);
  endtask

  task automatic test_capacity();
    logic [51:0] tag;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      tag = 52'h100 + 52'(i);
      refill(tag, 64'h1000 + 64'(i));
    end
    lookup(52'h100, 1'b0);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL cap_evicted got hit=%b exp 0", mlb_hit); end
    for (int i = 1; i <= 16; i++) begin
      tag = 52'h100 + 52'(i);
      lookup(tag, 1'b0);
      tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'h1000 + 64'(i)) begin
        tests_failed++; $display("FAIL cap_hit_%0d got hit=%b d0=%h exp 1/%h", i, mlb_hit, mlb_data0, 64'h1000 + 64'(i)); end
    end
    refill(52'h105, 64'hBEEF);
    lookup(52'h101, 1'b0);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'h1001) begin
      tests_failed++; $display("FAIL cap_no_evict got hit=%b d0=%h exp 1/1001", mlb_hit, mlb_data0); end
    lookup(52'h105, 1'b0);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'hBEEF) begin
      tests_failed++; $display("FAIL cap_rewrite got hit=%b d0=%h exp 1/beef", mlb_hit, mlb_data0); end
  endtask

  task automatic test_inv_all();
    tests_run++; if (miss_req !== 1'b1 || miss_addr !== 52'h100) begin
      tests_failed++; $display("FAIL inv_pre_req got req=%b addr=%h exp 1/100", miss_req, miss_addr); end
    ack();
    inv_all = 1'b1;
    refill_en = 1'b1;
    refill_addr = 52'h100;
    refill_data = 64'h99;
    @(negedge clk);
    inv_all = 1'b0;
    refill_en = 1'b0;
    tests_run++; if (miss_busy !== 1'b0 || miss_req !== 1'b0) begin
      tests_failed++; $display("FAIL inv_idle got busy=%b req=%b exp 0/0", miss_busy, miss_req); end
    lookup(52'h100, 1'b0);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL inv_drop_refill got hit=%b exp 0", mlb_hit); end
    lookup(52'h101, 1'b0);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL inv_miss_101 got hit=%b exp 0", mlb_hit); end
    lookup(52'h110, 1'b0);
    tests_run++; if (mlb_hit !== 1'b0) begin tests_failed++; $display("FAIL inv_miss_110 got hit=%b exp 0", mlb_hit); end
`ifdef DMLB_RESP_STATS_EN
    tests_run++; if (stat_hits !== 32'd18 || stat_misses !== 32'd4) begin
      tests_failed++; $display("FAIL stats got %0d/%0d exp 18/4", stat_hits, stat_misses); end
`else
    tests_run++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      tests_failed++; $display("FAIL stats_tied got %0d/%0d exp 0/0", stat_hits, stat_misses); end
`endif
  endtask

  task automatic test_no_bypass();
    mlb_clkEn = 1'b1;
    addrTlb = 52'h500;
    mlb_need_next = 1'b0;
    refill_en = 1'b1;
    refill_addr = 52'h500;
    refill_data = 64'h55;
    @(negedge clk);
    mlb_clkEn = 1'b0;
    refill_en = 1'b0;
    tests_run++; if (mlb_hit !== 1'b0 || mlb_data0 !== 64'h0) begin
      tests_failed++; $display("FAIL bypass_same got hit=%b d0=%h exp 0/0", mlb_hit, mlb_data0); end
    lookup(52'h500, 1'b0);
    tests_run++; if (mlb_hit !== 1'b1 || mlb_data0 !== 64'h55) begin
      tests_failed++; $display("FAIL bypass_after got hit=%b d0=%h exp 1/55", mlb_hit, mlb_data0); end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_split();
    test_wrap();
    test_capacity();
    test_inv_all();
    test_no_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmlb_resp.md
DMLB_RESP -- requirements
Module: dmlb_resp

Interface
REQ-001 Parameter ENTRIES, default 16, number of fully-associative entries (power of 2, 4..64).
REQ-002 Parameter DATA_WIDTH, default 64, translation payload width, opaque to this block.
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mlb_clkEn  input  1  lookup strobe from address-calc requester.
REQ-006 addrTlb  input  52  lookup tag {proc[20:0], VA[43:13]}.
REQ-007 mlb_need_next  input  1  requester also needs page+1 (split access).
REQ-008 mlb_data0  output  DATA_WIDTH  payload for page.
REQ-009 mlb_data1  output  DATA_WIDTH  payload for page+1.
REQ-010 mlb_hit  output  1  lookup fully satisfied.
REQ-011 miss_req  output  1  refill request to walker.
REQ-012 miss_addr  output  52  tag being requested.
REQ-013 miss_ack  input  1  walker accepted miss_req.
REQ-014 refill_en, refill_addr[51:0], refill_data[DATA_WIDTH-1:0]  inputs  entry write from walker.
REQ-015 inv_all  input  1  flush all entries.
REQ-016 miss_busy  output  1  FSM not IDLE.
REQ-017 stat_hits, stat_misses  output  32 each  lookup statistics.

Function
REQ-018 Next tag = {addrTlb[51:31], addrTlb[30:0]+1}; low 31 bits wrap 7FFFFFFF->0, proc field never changes.
REQ-019 Lookup registered: mlb_data0/1, mlb_hit valid exactly 1 cycle after mlb_clkEn; hold last values otherwise.
REQ-020 hit0 = valid entry tag==page; hit1 = valid entry tag==next; mlb_hit = hit0 & (hit1 | ~mlb_need_next).
REQ-021 Missing side's payload output = 0; multiple tag matches impossible by REQ-026.
REQ-022 FSM states IDLE, REQ, WAIT; reset state IDLE.
REQ-023 IDLE: registered lookup with mlb_hit=0 -> REQ, miss_addr = page if ~hit0 else next tag.
REQ-024 REQ: miss_req=1, miss_addr stable; miss_ack -> WAIT same edge; miss_req drops next cycle.
REQ-025 WAIT: refill_en with refill_addr==miss_addr -> IDLE; non-matching refill still written, state kept.
REQ-026 Refill write: if refill_addr already valid in entry k, overwrite k; else write entry at victim pointer, pointer += 1 mod ENTRIES.
REQ-027 Misses during REQ/WAIT report mlb_hit=0, are not queued; requester replays.
REQ-028 Lookup and refill same cycle, same tag: lookup uses pre-write contents (miss); no bypass.
REQ-029 inv_all: all valid bits cleared, FSM -> IDLE, miss_req deasserted next cycle; coincident refill_en dropped; victim pointer kept.
REQ-030 Lookup in cycle after inv_all misses.

Reset
REQ-031 rst clears all valid bits, victim pointer=0, FSM=IDLE, miss_req=0, miss_addr=0, mlb_hit=0, mlb_data0/1=0, stat counters=0.
REQ-032 rst mid-REQ/WAIT abandons the miss; a later refill_en is a normal write.

Configuration
REQ-033 Macro DMLB_RESP_STATS_EN defined: stat_hits/stat_misses count registered lookups with mlb_hit 1/0, saturate at FFFFFFFF, cleared by rst only.
REQ-034 Macro undefined: stat ports present, tied 0, no counter flops.

Verification
REQ-035 Reset, lookup 0x0000000001000 -> next cycle mlb_hit=0, then miss_req=1, miss_addr=0x0000000001000.
REQ-036 miss_ack, refill_en addr 0x0000000001000 data 0xAB -> IDLE; lookup with need_next=0 -> mlb_hit=1, mlb_data0=0xAB, mlb_data1=0.
REQ-037 Same lookup, need_next=1, page+1 absent -> mlb_hit=0, miss_addr=0x0000000001001; refill 0xCD -> hit, data1=0xCD.
REQ-038 Lookup tag 0x00000_7FFFFFFF, need_next=1 -> next tag 0x0000000000000 (proc unchanged).
REQ-039 Refill 17 distinct tags into 16 entries -> first tag misses, 2nd-17th hit; rewriting an existing tag evicts nothing.
REQ-040 inv_all during WAIT with coincident refill -> miss_busy=0 next cycle, all lookups miss, stat_misses increments (STATS_EN).
